// File: rtl/axis_inject_arbiter.sv
// Packet-atomic round-robin arbiter feeding one AXI-Stream mesh injection port.
// The grant is held from a packet's first beat through its TLAST beat; output is a single register slice.
module axis_inject_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TDATAW  = 32,
  parameter int TDESTW  = 4,
  parameter int CNTW    = 16,
  parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        S_TVALID,
  output logic [NUM_REQ-1:0]        S_TREADY,
  input  logic [NUM_REQ*TDATAW-1:0] S_TDATA,
  input  logic [NUM_REQ-1:0]        S_TLAST,
  input  logic [NUM_REQ*TDESTW-1:0] S_TDEST,
  output logic                      M_TVALID,
  input  logic                      M_TREADY,
  output logic [TDATAW-1:0]         M_TDATA,
  output logic                      M_TLAST,
  output logic [TDESTW-1:0]         M_TDEST,
  output logic [IDXW-1:0]           GRANT_IDX,
  output logic                      BUSY,
  output logic [NUM_REQ*CNTW-1:0]   PKT_CNT
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                          r_state;
  logic [IDXW-1:0]                 r_grant;
  logic [IDXW-1:0]                 r_last;
  logic                            r_mvalid;
  logic [TDATAW-1:0]               r_mdata;
  logic                            r_mlast;
  logic [TDESTW-1:0]               r_mdest;
  logic [NUM_REQ-1:0][CNTW-1:0]    r_cnt;

  logic                            w_ready_g;
  logic                            w_accept;
  logic [TDATAW-1:0]               w_sel_data;
  logic                            w_sel_last;
  logic [TDESTW-1:0]               w_sel_dest;
  logic [IDXW-1:0]                 w_next;

  // Round-robin search starting just after the most recently completed grant.
  function automatic logic [IDXW-1:0] pick_next(input logic [NUM_REQ-1:0] req,
                                                input logic [IDXW-1:0]    last);
    logic [IDXW-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IDXW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_ready_g  = (r_state == ST_LOCKED) && (!r_mvalid || M_TREADY);
  assign w_accept   = w_ready_g && S_TVALID[r_grant];
  assign w_sel_data = S_TDATA[int'(r_grant)*TDATAW +: TDATAW];
  assign w_sel_last = S_TLAST[r_grant];
  assign w_sel_dest = S_TDEST[int'(r_grant)*TDESTW +: TDESTW];
  assign w_next     = pick_next(S_TVALID, r_last);

  always_comb begin
    S_TREADY = '0;
    if (w_ready_g) S_TREADY[r_grant] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_last   <= IDXW'(NUM_REQ - 1);
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mlast  <= 1'b0;
      r_mdest  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|S_TVALID) begin
            r_grant <= w_next;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_sel_last) begin
            r_state        <= ST_IDLE;
            r_last         <= r_grant;
            r_cnt[r_grant] <= r_cnt[r_grant] + CNTW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Load wins over drain so back-to-back beats keep full throughput.
      if (w_accept) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_sel_data;
        r_mlast  <= w_sel_last;
        r_mdest  <= w_sel_dest;
      end else if (M_TREADY) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign M_TVALID  = r_mvalid;
  assign M_TDATA   = r_mdata;
  assign M_TLAST   = r_mlast;
  assign M_TDEST   = r_mdest;
  assign GRANT_IDX = r_grant;
  assign BUSY      = (r_state == ST_LOCKED);
  assign PKT_CNT   = r_cnt;

endmodule

// File: tb/tb_axis_inject_arbiter.sv
// Directed bench for axis_inject_arbiter: packet ordering, latency, back-pressure, reset and counter wrap.
module tb_axis_inject_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tdest;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tdest;
  logic [0:0]  grant_idx;
  logic        busy;
  logic [31:0] pkt_cnt;

  logic [1:0]  s2_tvalid, s2_tready, s2_tlast;
  logic [15:0] s2_tdata;
  logic [7:0]  s2_tdest;
  logic        m2_tvalid, m2_tready, m2_tlast;
  logic [7:0]  m2_tdata;
  logic [3:0]  m2_tdest;
  logic [0:0]  grant2;
  logic        busy2;
  logic [3:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  logic [31:0] cap_d[$];
  logic        cap_l[$];
  logic [3:0]  cap_t[$];
  int          cap_c[$];
  int          rdy1_c[$];

  always #5 clk = ~clk;

  axis_inject_arbiter u_dut (
    .CLK(clk), .RST(rst),
    .S_TVALID(s_tvalid), .S_TREADY(s_tready), .S_TDATA(s_tdata),
    .S_TLAST(s_tlast), .S_TDEST(s_tdest),
    .M_TVALID(m_tvalid), .M_TREADY(m_tready), .M_TDATA(m_tdata),
    .M_TLAST(m_tlast), .M_TDEST(m_tdest),
    .GRANT_IDX(grant_idx), .BUSY(busy), .PKT_CNT(pkt_cnt)
  );

  axis_inject_arbiter #(.NUM_REQ(2), .TDATAW(8), .TDESTW(4), .CNTW(2)) u_dut2 (
    .CLK(clk), .RST(rst),
    .S_TVALID(s2_tvalid), .S_TREADY(s2_tready), .S_TDATA(s2_tdata),
    .S_TLAST(s2_tlast), .S_TDEST(s2_tdest),
    .M_TVALID(m2_tvalid), .M_TREADY(m2_tready), .M_TDATA(m2_tdata),
    .M_TLAST(m2_tlast), .M_TDEST(m2_tdest),
    .GRANT_IDX(grant2), .BUSY(busy2), .PKT_CNT(cnt2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: every handshake on the mesh side, plus cycles where requester 1 is ready.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      cap_d.push_back(m_tdata);
      cap_l.push_back(m_tlast);
      cap_t.push_back(m_tdest);
      cap_c.push_back(cyc);
    end
    if (s_tready[1]) rdy1_c.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tdest = '0;
    s2_tvalid = '0; s2_tlast = '0; s2_tdata = '0; s2_tdest = '0;
    m_tready = 1'b1; m2_tready = 1'b1;
    step();
    step();
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_pkt(input int r, input int n, input logic [31:0] d0, input logic [3:0] dest);
    int guard;
    bit acc;
    for (int b = 0; b < n; b++) begin
      s_tvalid[r]           = 1'b1;
      s_tdata[r*32 +: 32]   = d0 + b;
      s_tlast[r]            = (b == n - 1);
      s_tdest[r*4 +: 4]     = dest;
      guard = 0;
      acc   = 1'b0;
      do begin
        @(negedge clk);
        acc = s_tvalid[r] && s_tready[r];
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        check("send_timeout", 64'(acc), 64'd1);
        break;
      end
    end
    s_tvalid[r] = 1'b0;
    s_tlast[r]  = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    do_reset();

    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_mdata",  64'(m_tdata),  64'd0);
    check("rst_mlast",  64'(m_tlast),  64'd0);
    check("rst_mdest",  64'(m_tdest),  64'd0);
    check("rst_sready", 64'(s_tready), 64'd0);
    check("rst_grant",  64'(grant_idx), 64'd0);
    check("rst_busy",   64'(busy),     64'd0);
    check("rst_cnt",    64'(pkt_cnt),  64'd0);

    // Single 4-beat packet from requester 0.
    base = cap_d.size();
    send_pkt(0, 4, 32'd1, 4'd1);
    step();
    check("t1_count", 64'(cap_d.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < cap_d.size()) begin
        check($sformatf("t1_data%0d", i), 64'(cap_d[base+i]), 64'(i + 1));
        check($sformatf("t1_last%0d", i), 64'(cap_l[base+i]), 64'(i == 3));
        check($sformatf("t1_dest%0d", i), 64'(cap_t[base+i]), 64'd1);
        check($sformatf("t1_cyc%0d", i),  64'(cap_c[base+i] - t0), 64'(i + 2));
      end
    end
    check("t1_mvalid_after", 64'(m_tvalid), 64'd0);
    check("t1_busy_after",   64'(busy),     64'd0);
    check("t1_cnt0",         64'(pkt_cnt[15:0]), 64'd1);

    // Both requesters continuously ready: strict alternation with one idle cycle between packets.
    do_reset();
    base = cap_d.size();
    fork
      begin send_pkt(0, 3, 32'h10, 4'd2); send_pkt(0, 3, 32'h20, 4'd2); end
      begin send_pkt(1, 3, 32'h30, 4'd3); send_pkt(1, 3, 32'h40, 4'd3); end
    join
    step();
    begin
      logic [31:0] exp_d[12];
      int          exp_c[12];
      exp_d = '{32'h10, 32'h11, 32'h12, 32'h30, 32'h31, 32'h32,
                32'h20, 32'h21, 32'h22, 32'h40, 32'h41, 32'h42};
      exp_c = '{2, 3, 4, 6, 7, 8, 10, 11, 12, 14, 15, 16};
      check("t2_count", 64'(cap_d.size() - base), 64'd12);
      for (int i = 0; i < 12; i++) begin
        if (base + i < cap_d.size()) begin
          check($sformatf("t2_data%0d", i), 64'(cap_d[base+i]), 64'(exp_d[i]));
          check($sformatf("t2_cyc%0d", i),  64'(cap_c[base+i] - t0), 64'(exp_c[i]));
          check($sformatf("t2_last%0d", i), 64'(cap_l[base+i]), 64'(i % 3 == 2));
        end
      end
    end
    check("t2_cnt0", 64'(pkt_cnt[15:0]),  64'd2);
    check("t2_cnt1", 64'(pkt_cnt[31:16]), 64'd2);

    // Late request from requester 1 waits for requester 0's TLAST.
    do_reset();
    base = cap_d.size();
    fork
      send_pkt(0, 4, 32'h50, 4'd4);
      begin step(); step(); send_pkt(1, 2, 32'h60, 4'd6); end
    join
    step();
    begin
      logic [31:0] exp_d[6];
      int          rbase;
      exp_d = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h60, 32'h61};
      check("t3_count", 64'(cap_d.size() - base), 64'd6);
      for (int i = 0; i < 6; i++)
        if (base + i < cap_d.size())
          check($sformatf("t3_data%0d", i), 64'(cap_d[base+i]), 64'(exp_d[i]));
      rbase = -1;
      for (int i = 0; i < rdy1_c.size(); i++)
        if (rbase < 0 && rdy1_c[i] >= t0) rbase = rdy1_c[i] - t0;
      check("t3_first_rdy1", 64'(rbase), 64'd6);
    end

    // Back-pressure for 5 cycles mid-packet.
    do_reset();
    base = cap_d.size();
    fork
      send_pkt(0, 4, 32'h70, 4'd5);
      begin
        repeat (3) @(posedge clk);
        #1;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #1;
          check($sformatf("t4_hold_data%0d", i), 64'(m_tdata), 64'h71);
          check($sformatf("t4_hold_last%0d", i), 64'(m_tlast), 64'd0);
          check($sformatf("t4_hold_dest%0d", i), 64'(m_tdest), 64'd5);
          check($sformatf("t4_hold_rdy%0d", i),  64'(s_tready[0]), 64'd0);
          check($sformatf("t4_hold_vld%0d", i),  64'(m_tvalid), 64'd1);
          step();
        end
        m_tready = 1'b1;
      end
    join
    step();
    step();
    check("t4_count", 64'(cap_d.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < cap_d.size())
        check($sformatf("t4_data%0d", i), 64'(cap_d[base+i]), 64'(32'h70 + i));

    // Reset after the second beat of a 4-beat packet.
    do_reset();
    s_tvalid[0] = 1'b1; s_tdata[31:0] = 32'h80; s_tlast[0] = 1'b0; s_tdest[3:0] = 4'd8;
    step();
    step();
    s_tdata[31:0] = 32'h81;
    step();
    rst = 1'b1;
    s_tvalid = '0;
    step();
    rst = 1'b0;
    check("t5_mvalid", 64'(m_tvalid), 64'd0);
    check("t5_mdata",  64'(m_tdata),  64'd0);
    check("t5_mlast",  64'(m_tlast),  64'd0);
    check("t5_mdest",  64'(m_tdest),  64'd0);
    check("t5_sready", 64'(s_tready), 64'd0);
    check("t5_grant",  64'(grant_idx), 64'd0);
    check("t5_busy",   64'(busy),     64'd0);
    check("t5_cnt",    64'(pkt_cnt),  64'd0);
    base = cap_d.size();
    fork
      send_pkt(1, 1, 32'h91, 4'd6);
      send_pkt(0, 1, 32'h90, 4'd7);
    join
    step();
    step();
    check("t5_count", 64'(cap_d.size() - base), 64'd2);
    if (cap_d.size() - base >= 2) begin
      check("t5_first_data",  64'(cap_d[base]),   64'h90);
      check("t5_first_dest",  64'(cap_t[base]),   64'd7);
      check("t5_second_data", 64'(cap_d[base+1]), 64'h91);
    end

    // Counter wrap on the CNTW=2 instance with single-beat packets.
    do_reset();
    s2_tvalid[0] = 1'b1; s2_tlast[0] = 1'b1; s2_tdata[7:0] = 8'hA5; s2_tdest[3:0] = 4'd3;
    begin
      logic [3:0] exp_w[5];
      exp_w = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
      for (int i = 0; i < 5; i++) begin
        step();
        step();
        check($sformatf("t6_cnt%0d", i), 64'(cnt2[1:0]), 64'(exp_w[i]));
      end
    end
    s2_tvalid = '0;
    step();
    check("t6_cnt1_idle", 64'(cnt2[3:2]), 64'd0);
    check("t6_mdata", 64'(m2_tdata), 64'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_inject_arbiter.md
Name: axis_inject_arbiter

Overview:
- Packet-atomic round-robin arbiter that lets NUM_REQ AXI-Stream traffic sources (e.g. num_gen instances) share one axis_mesh router injection port.
- Sits between the requesters' master interfaces and a single axis_in_* port of the mesh.
- Locks the grant from the first beat of a packet until its TLAST beat, so flits from different packets never interleave.
- Drives the mesh through a registered output stage, and keeps a per-requester count of forwarded packets.

Parameters:
- NUM_REQ, 2, number of requesters (>=1)
- TDATAW, 32, TDATA width
- TDESTW, 4, TDEST width
- CNTW, 16, width of each per-requester packet counter
- IDXW, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), grant index width (derived; do not override)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- S_TVALID  in  NUM_REQ  requester valid, bit r = requester r
- S_TREADY  out  NUM_REQ  requester ready
- S_TDATA  in  NUM_REQ*TDATAW  requester data, slice r = [r*TDATAW +: TDATAW]
- S_TLAST  in  NUM_REQ  requester end-of-packet
- S_TDEST  in  NUM_REQ*TDESTW  requester destination, slice r = [r*TDESTW +: TDESTW]
- M_TVALID  out  1  to mesh axis_in_tvalid
- M_TREADY  in  1  from mesh axis_in_tready
- M_TDATA  out  TDATAW  to mesh
- M_TLAST  out  1  to mesh
- M_TDEST  out  TDESTW  to mesh
- GRANT_IDX  out  IDXW  current or most recent granted requester
- BUSY  out  1  1 while in LOCKED
- PKT_CNT  out  NUM_REQ*CNTW  packets forwarded per requester, slice r = [r*CNTW +: CNTW]

Behaviour:

Reset (RST=1 at an edge):
- M_TVALID=0, M_TDATA=0, M_TLAST=0, M_TDEST=0
- S_TREADY=0, GRANT_IDX=0, BUSY=0, all PKT_CNT=0
- State=IDLE; internal last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-packet discards the output register and abandons the packet; no partial-packet recovery.

FSM:
- IDLE: S_TREADY=0. If any S_TVALID is set, pick the first set bit searching (last_grant+1) mod NUM_REQ upward with wrap-around. Register it into GRANT_IDX and go to LOCKED at the next edge. No request: stay in IDLE.
- LOCKED: S_TREADY[GRANT_IDX] = (!M_TVALID || M_TREADY); all other S_TREADY bits = 0.
  - A beat is accepted when S_TVALID[g] && S_TREADY[g].
  - Accepted beat with S_TLAST[g]=1: go to IDLE, last_grant<=g, PKT_CNT[g]++ (wraps modulo 2^CNTW).
  - Granted requester deasserting TVALID mid-packet keeps the lock (stall); other requesters are not served.

Output stage (single register):
- Loads {TDATA, TLAST, TDEST} of the accepted beat and sets M_TVALID=1.
- M_TVALID clears on M_TREADY when no new beat is accepted in the same cycle.
- Simultaneous drain and load: the register takes the new beat and M_TVALID stays 1 (full throughput).
- Output fields hold stable while M_TVALID && !M_TREADY (AXIS rule).

Latency and throughput:
- Request in IDLE at cycle 0 -> grant at edge 1 -> first beat accepted at edge 2 -> M_TVALID=1 in cycle 2.
- Throughput inside a packet: 1 beat/cycle.
- One idle arbitration cycle between consecutive packets.
- Single-beat packet (TLAST on first beat) is legal: LOCKED lasts one cycle.
- TLAST acceptance with new requests pending: arbitration happens in the following IDLE cycle using the updated last_grant.

Other rules:
- GRANT_IDX holds its value in IDLE until the next grant.
- NUM_REQ=1: always grants 0; behaviour is otherwise identical.

Test Plan:
- Reset, then requester 0 sends a 4-beat packet (data 1..4, TDEST=1) with M_TREADY=1 -> M_TVALID high cycles 2..5; data 1,2,3,4 in order; M_TLAST only on 4; M_TDEST=1; PKT_CNT[0]=1; BUSY low after.
- Both requesters hold a 3-beat packet ready continuously -> packets alternate 0,1,0,1; no interleaving within a packet; one idle cycle between packets; after 4 packets PKT_CNT[0]=PKT_CNT[1]=2.
- Requester 1 raises TVALID during requester 0's packet -> requester 1 is granted only after 0's TLAST beat leaves the input; S_TREADY[1]=0 until then.
- M_TREADY held low for 5 cycles mid-packet -> M_TDATA, M_TLAST and M_TDEST stay constant; S_TREADY[g]=0 while the register is full; no beat lost or duplicated.
- Assert RST for 1 cycle after beat 2 of a 4-beat packet -> next cycle all outputs equal their reset values; a new packet from requester 1 is then granted to requester 0 first if both request.
- CNTW=2: requester 0 sends 5 single-beat packets -> PKT_CNT[0] reads 1,2,3,0,1.
